// File: rtl/spi_frame_slave.sv
// SPI target for the host link. spi_clk/cs/frame/mosi are oversampled on clk,
// data moves LSB-first. Frame mode (spi_frame=0) carries 32-bit words and OOB
// mode (spi_frame=1) carries standalone bytes. Received words/bytes go to the
// command decoder, and response words/status bytes are returned on spi_miso.
module spi_frame_slave #(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] TX_IDLE_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic        spi_cs,
    input  logic        spi_frame,
    output logic [31:0] rx_word,
    output logic        rx_word_valid,
    output logic [7:0]  rx_oob,
    output logic        rx_oob_valid,
    input  logic [31:0] tx_word,
    input  logic        tx_word_valid,
    output logic        tx_word_ready,
    output logic        tx_underrun,
    input  logic [7:0]  tx_oob,
    output logic        frame_start,
    output logic        frame_end
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OOB  = 2'd1,
        ST_WORD = 2'd2
    } state_t;

    // Each pipe has SYNC_STAGES synchroniser flops plus one alignment flop.
    // spi_clk and spi_frame have one further flop so that edges can be
    // detected. Every line reaches its "current" tap with the same latency,
    // so a cs/frame change and an spi_clk edge issued together by the master
    // are seen in the same clk cycle.
    localparam int SL = SYNC_STAGES + 1;
    localparam int EL = SYNC_STAGES + 2;

    logic [EL-1:0] sclk_pipe_r;
    logic [EL-1:0] frame_pipe_r;
    logic [SL-1:0] cs_pipe_r;
    logic [SL-1:0] mosi_pipe_r;

    logic          sclk_rise_s;
    logic          sclk_fall_s;
    logic          frame_rise_s;
    logic          frame_fall_s;
    logic          cs_s;
    logic          frame_s;
    logic          mosi_s;

    state_t        state_r;
    state_t        want_s;
    logic          change_s;
    logic [5:0]    last_bit_s;
    logic          rx_done_s;
    logic          tx_wrap_s;
    logic          load_oob_s;
    logic          load_word_s;
    logic [31:0]   tx_sr_next_s;

    logic [5:0]    bit_cnt_r;
    logic [5:0]    tx_cnt_r;
    logic [31:0]   rx_sr_r;
    logic [31:0]   tx_sr_r;

    // Pin synchronisers. They are deliberately left out of reset so that they
    // keep tracking the pins during reset, and release produces no false edges.
    always_ff @(posedge clk) begin
        sclk_pipe_r  <= {sclk_pipe_r[EL-2:0], spi_clk};
        frame_pipe_r <= {frame_pipe_r[EL-2:0], spi_frame};
        cs_pipe_r    <= {cs_pipe_r[SL-2:0], spi_cs};
        mosi_pipe_r  <= {mosi_pipe_r[SL-2:0], spi_mosi};
    end

    assign cs_s         = cs_pipe_r[SL-1];
    assign mosi_s       = mosi_pipe_r[SL-1];
    assign frame_s      = frame_pipe_r[EL-2];
    assign sclk_rise_s  = sclk_pipe_r[EL-2] & ~sclk_pipe_r[EL-1];
    assign sclk_fall_s  = ~sclk_pipe_r[EL-2] & sclk_pipe_r[EL-1];
    assign frame_rise_s = frame_pipe_r[EL-2] & ~frame_pipe_r[EL-1];
    assign frame_fall_s = ~frame_pipe_r[EL-2] & frame_pipe_r[EL-1];

    // Target mode follows the synchronised cs/frame levels; any difference from the current state is a transition.
    always_comb begin
        want_s = ST_IDLE;
        if (cs_s) begin
            want_s = ST_IDLE;
        end else if (frame_s) begin
            want_s = ST_OOB;
        end else begin
            want_s = ST_WORD;
        end
    end

    assign change_s   = (want_s != state_r);
    assign last_bit_s = (state_r == ST_OOB) ? 6'd7 : 6'd31;

    // A completing rise still delivers its data when a transition occurs in the same cycle.
    assign rx_done_s  = sclk_rise_s && (state_r != ST_IDLE) && (bit_cnt_r == last_bit_s);

    // A final fall that coincides with a transition does not reload: the entry load, or IDLE, takes over.
    assign tx_wrap_s  = sclk_fall_s && (state_r != ST_IDLE) && !change_s && (tx_cnt_r == last_bit_s);

    assign load_oob_s  = (change_s && (want_s == ST_OOB))  || (tx_wrap_s && (state_r == ST_OOB));
    assign load_word_s = (change_s && (want_s == ST_WORD)) || (tx_wrap_s && (state_r == ST_WORD));

    // Next transmit shift register: a load takes priority over a shift on spi_clk fall.
    always_comb begin
        tx_sr_next_s = tx_sr_r;
        if (load_oob_s) begin
            tx_sr_next_s = {24'h00_0000, tx_oob};
        end else if (load_word_s) begin
            tx_sr_next_s = tx_word_valid ? tx_word : TX_IDLE_WORD;
        end else if (sclk_fall_s && (state_r != ST_IDLE) && !change_s) begin
            tx_sr_next_s = {1'b0, tx_sr_r[31:1]};
        end else begin
            tx_sr_next_s = tx_sr_r;
        end
    end

    // Mode FSM, bit counters, shift registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= 6'd0;
            tx_cnt_r      <= 6'd0;
            rx_sr_r       <= 32'h0000_0000;
            tx_sr_r       <= 32'h0000_0000;
            spi_miso      <= 1'b0;
            rx_word       <= 32'h0000_0000;
            rx_word_valid <= 1'b0;
            rx_oob        <= 8'h00;
            rx_oob_valid  <= 1'b0;
            tx_word_ready <= 1'b0;
            tx_underrun   <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
        end else begin
            state_r       <= want_s;
            rx_word_valid <= 1'b0;
            rx_oob_valid  <= 1'b0;
            tx_word_ready <= load_word_s && tx_word_valid;
            tx_underrun   <= load_word_s && !tx_word_valid;
            frame_start   <= frame_fall_s;
            frame_end     <= frame_rise_s;

            if (rx_done_s) begin
                if (state_r == ST_OOB) begin
                    rx_oob       <= {mosi_s, rx_sr_r[31:25]};
                    rx_oob_valid <= 1'b1;
                end else begin
                    rx_word       <= {mosi_s, rx_sr_r[31:1]};
                    rx_word_valid <= 1'b1;
                end
            end

            if (sclk_rise_s && (state_r != ST_IDLE)) begin
                rx_sr_r <= {mosi_s, rx_sr_r[31:1]};
            end

            if (change_s) begin
                bit_cnt_r <= 6'd0;
                tx_cnt_r  <= 6'd0;
            end else if (state_r != ST_IDLE) begin
                if (sclk_rise_s) begin
                    bit_cnt_r <= rx_done_s ? 6'd0 : bit_cnt_r + 6'd1;
                end
                if (sclk_fall_s) begin
                    tx_cnt_r <= tx_wrap_s ? 6'd0 : tx_cnt_r + 6'd1;
                end
            end

            tx_sr_r  <= tx_sr_next_s;
            spi_miso <= (want_s == ST_IDLE) ? 1'b0 : tx_sr_next_s[0];
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave. It acts as the SPI master (60 ns half
// period) and checks received data, read-back data and pulse counts against
// hand-computed values.
module tb_spi_frame_slave;

    logic        clk;
    logic        rst_n;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs;
    logic        spi_frame;
    logic [31:0] rx_word;
    logic        rx_word_valid;
    logic [7:0]  rx_oob;
    logic        rx_oob_valid;
    logic [31:0] tx_word;
    logic        tx_word_valid;
    logic        tx_word_ready;
    logic        tx_underrun;
    logic [7:0]  tx_oob;
    logic        frame_start;
    logic        frame_end;

    int n_vec = 0;
    int n_err = 0;

    int n_oob   = 0;
    int n_word  = 0;
    int n_ready = 0;
    int n_under = 0;
    int n_fend  = 0;

    spi_frame_slave #(
        .SYNC_STAGES (2),
        .TX_IDLE_WORD(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_cs       (spi_cs),
        .spi_frame    (spi_frame),
        .rx_word      (rx_word),
        .rx_word_valid(rx_word_valid),
        .rx_oob       (rx_oob),
        .rx_oob_valid (rx_oob_valid),
        .tx_word      (tx_word),
        .tx_word_valid(tx_word_valid),
        .tx_word_ready(tx_word_ready),
        .tx_underrun  (tx_underrun),
        .tx_oob       (tx_oob),
        .frame_start  (frame_start),
        .frame_end    (frame_end)
    );

    // 10 ns system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters, sampled on the falling edge away from register updates
    always @(negedge clk) begin
        if (rx_oob_valid)  n_oob   <= n_oob + 1;
        if (rx_word_valid) n_word  <= n_word + 1;
        if (tx_word_ready) n_ready <= n_ready + 1;
        if (tx_underrun)   n_under <= n_under + 1;
        if (frame_end)     n_fend  <= n_fend + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master transfer of n bits, LSB first; with end_cs, cs rises at the last fall.
    task automatic xfer(input logic [31:0] d, input int n, input bit end_cs, output logic [31:0] r);
        r = 32'h0000_0000;
        for (int i = 0; i < n; i++) begin
            spi_mosi = d[i];
            #60;
            r[i]     = spi_miso;
            spi_clk  = 1'b1;
            #60;
            spi_clk  = 1'b0;
            if (end_cs && (i == n - 1)) spi_cs = 1'b1;
        end
        spi_mosi = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rd2;
        logic [31:0] rd3;
        int b_oob;
        int b_word;
        int b_ready;
        int b_under;
        int b_fend;

        rst_n         = 1'b0;
        spi_clk       = 1'b0;
        spi_mosi      = 1'b0;
        spi_cs        = 1'b1;
        spi_frame     = 1'b0;
        tx_word       = 32'h0000_0000;
        tx_word_valid = 1'b0;
        tx_oob        = 8'h00;
        #52;
        rst_n = 1'b1;
        check("reset_state", {17'h0, rx_word, rx_oob, rx_word_valid, rx_oob_valid, tx_word_ready,
                              tx_underrun, frame_start, frame_end, spi_miso}, 64'h0);
        #100;

        // 1. OOB byte exchange
        tx_oob    = 8'hA5;
        b_oob     = n_oob;
        spi_frame = 1'b1;
        spi_cs    = 1'b0;
        #100;
        xfer(32'h0000_003C, 8, 1'b1, rd);
        #200;
        check("oob_rx", {56'h0, rx_oob}, 64'h3C);
        check("oob_pulses", n_oob - b_oob, 64'd1);
        check("oob_miso", rd, 64'hA5);

        // 2. Single frame word
        spi_frame     = 1'b0;
        tx_word       = 32'h1234_5678;
        tx_word_valid = 1'b1;
        #100;
        b_word  = n_word;
        b_ready = n_ready;
        b_under = n_under;
        spi_cs  = 1'b0;
        #100;
        tx_word_valid = 1'b0;
        xfer(32'hDEAD_BEEF, 32, 1'b1, rd);
        #200;
        check("word_rx", rx_word, 64'hDEAD_BEEF);
        check("word_pulses", n_word - b_word, 64'd1);
        check("word_miso", rd, 64'h1234_5678);
        check("word_ready", n_ready - b_ready, 64'd1);
        check("word_underrun", n_under - b_under, 64'd0);

        // 3. Back-to-back words, tx word offered only for the first
        tx_word       = 32'hA1B2_C3D4;
        tx_word_valid = 1'b1;
        b_word  = n_word;
        b_ready = n_ready;
        b_under = n_under;
        spi_cs  = 1'b0;
        #100;
        tx_word_valid = 1'b0;
        xfer(32'h0102_0304, 32, 1'b0, rd);
        check("b2b_rx1", rx_word, 64'h0102_0304);
        xfer(32'h8765_4321, 32, 1'b0, rd2);
        check("b2b_rx2", rx_word, 64'h8765_4321);
        xfer(32'h0F0F_F0F0, 32, 1'b1, rd3);
        #200;
        check("b2b_rx3", rx_word, 64'h0F0F_F0F0);
        check("b2b_pulses", n_word - b_word, 64'd3);
        check("b2b_ready", n_ready - b_ready, 64'd1);
        check("b2b_underrun", n_under - b_under, 64'd2);
        check("b2b_miso1", rd, 64'hA1B2_C3D4);
        check("b2b_miso2", rd2, 64'h0);
        check("b2b_miso3", rd3, 64'h0);

        // 4. Word aborted by spi_frame rise after 13 bits, then an OOB byte
        spi_frame = 1'b0;
        spi_cs    = 1'b0;
        tx_oob    = 8'h5A;
        #100;
        b_word = n_word;
        b_fend = n_fend;
        b_oob  = n_oob;
        xfer(32'hFFFF_FFFF, 13, 1'b0, rd);
        #60;
        spi_frame = 1'b1;
        #100;
        check("abort_no_word", n_word - b_word, 64'd0);
        check("abort_frame_end", n_fend - b_fend, 64'd1);
        xfer(32'h0000_0081, 8, 1'b1, rd);
        #200;
        check("abort_oob_rx", {56'h0, rx_oob}, 64'h81);
        check("abort_oob_pulses", n_oob - b_oob, 64'd1);
        check("abort_oob_miso", rd, 64'h5A);

        // 5. Reset pulse mid-byte
        tx_oob = 8'hC3;
        spi_cs = 1'b0;
        #100;
        xfer(32'h0000_00FF, 4, 1'b0, rd);
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        check("midreset_outputs", {17'h0, rx_word, rx_oob, rx_word_valid, rx_oob_valid, tx_word_ready,
                                   tx_underrun, frame_start, frame_end, spi_miso}, 64'h0);
        spi_cs = 1'b1;
        #200;
        b_oob  = n_oob;
        spi_cs = 1'b0;
        #100;
        xfer(32'h0000_0055, 8, 1'b1, rd);
        #200;
        check("postreset_rx", {56'h0, rx_oob}, 64'h55);
        check("postreset_pulses", n_oob - b_oob, 64'd1);
        check("postreset_miso", rd, 64'hC3);

        // 6. cs rise after 5 bits, then a fresh byte
        tx_oob = 8'h3D;
        b_oob  = n_oob;
        spi_cs = 1'b0;
        #100;
        xfer(32'h0000_001F, 5, 1'b0, rd);
        #60;
        spi_cs = 1'b1;
        #200;
        check("short_no_pulse", n_oob - b_oob, 64'd0);
        spi_cs = 1'b0;
        #100;
        xfer(32'h0000_0096, 8, 1'b1, rd);
        #200;
        check("restart_rx", {56'h0, rx_oob}, 64'h96);
        check("restart_pulses", n_oob - b_oob, 64'd1);
        check("restart_miso", rd, 64'h3D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
